draw_pixel_datapath: RTL
========================

Name: draw_pixel_datapath

Overview:
- Datapath end of the sprite/text drawing handshake; sits between any drawing FSM (ld_xy / ld_pos / ld_colour / draw_pixel / dx / dy / x / y / colour) and the VGA adapter write port.
- Latches the base origin, forms the absolute pixel position and latches the colour.
- Clips off-screen and transparent pixels, then queues accepted pixels in a small FIFO drained with a ready/valid handshake to the VGA adapter.

Parameters:
- SCREEN_W, 320, visible width in pixels; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 240, visible height in pixels; pixels with y >= SCREEN_H are clipped.
- TRANSPARENT, 9'h1FF, colour value that is never plotted.
- DEPTH, 4, FIFO entries; must be a power of two, >= 2.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- ld_xy  in  1  latch base_x <= x, base_y <= y
- ld_pos  in  1  latch pos_x <= base_x+dx, pos_y <= base_y+dy
- ld_colour  in  1  latch col_reg <= colour
- draw_pixel  in  1  request plot of {pos_x,pos_y,col_reg}
- x, y  in  9 each  base origin from drawing FSM
- dx, dy  in  9 each  offset from origin
- colour  in  9  pixel colour (ROM output)
- clear_status  in  1  synchronous clear of overflow and counters
- vga_ready  in  1  adapter accepts the head pixel this cycle
- vga_plot  out  1  head pixel valid (FIFO not empty)
- vga_x, vga_y  out  9 each  head pixel coordinates
- vga_colour  out  9  head pixel colour
- busy  out  1  FIFO not empty
- overflow  out  1  sticky: a pixel was dropped on a full FIFO
- pixel_count  out  16  saturating count of pixels handed to the VGA adapter
- clip_count  out  8  saturating count of clipped or transparent pixels

Behaviour:
- Reset (async, active-high) clears all registers and outputs to 0: base_x, base_y, pos_x, pos_y, col_reg, FIFO pointers and occupancy, overflow, pixel_count, clip_count. vga_plot=0, busy=0, vga_x=vga_y=vga_colour=0.
- Reset asserted mid-operation discards all queued pixels; nothing further is plotted until new draw_pixel requests arrive.
- Load registers:
  - ld_xy, ld_pos and ld_colour update independently on the same edge.
  - ld_pos uses base_x/base_y as they were before that edge, so ld_xy and ld_pos asserted together use the old base.
- Position sums are computed 10 bits wide. Carry set => off-screen (clipped). Stored pos_x/pos_y keep a 10th bit for the clip test.
- draw_pixel samples pos_x, pos_y and col_reg as they were before that edge, so ld_pos and ld_colour in the same cycle do not affect this pixel.
- Accept rule on draw_pixel:
  - Clipped if pos_x >= SCREEN_W, pos_y >= SCREEN_H, or col_reg == TRANSPARENT. clip_count++ (saturates at 255); nothing is queued.
  - Otherwise push {pos_x[8:0], pos_y[8:0], col_reg}.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and a count register 0..DEPTH; wrap-around modulo DEPTH.
  - Pop when vga_plot && vga_ready; pixel_count++ (saturates at 65535).
  - vga_plot, vga_x, vga_y and vga_colour are driven from the head entry (registered storage, combinational read). Zero latency from an empty-FIFO push: the pixel appears on the cycle after draw_pixel.
  - vga_x, vga_y and vga_colour hold their last value when the FIFO is empty.
- Boundary cases:
  - Full, push with no pop: pixel dropped, overflow <= 1, count unchanged.
  - Full, push and pop in the same cycle: both occur, count stays DEPTH, no overflow.
  - Empty: no pop is possible; vga_ready is ignored.
- clear_status: synchronously zeroes overflow, pixel_count and clip_count. If it coincides with an increment, the clear wins (result 0). It does not touch the FIFO.
- Throughput: 1 pixel/cycle sustained when vga_ready is held high.

Test Plan:
- Reset, then ld_xy(x=230,y=20); ld_pos(dx=5,dy=3); ld_colour(9'h0A5); draw_pixel; vga_ready=1 -> one cycle later vga_plot=1 with vga_x=235, vga_y=23, vga_colour=9'h0A5; popped; pixel_count=1, busy=0.
- Base x=300, dx=25 -> pos_x=325 >= 320: no vga_plot, clip_count=1. Repeat with col_reg=9'h1FF on-screen -> clip_count=2.
- Hold vga_ready=0 and issue 5 valid draw_pixel -> first 4 are queued (busy=1), 5th is dropped, overflow=1. Then vga_ready=1 -> 4 pixels emerge in order, pixel_count=4, overflow stays 1 until clear_status.
- FIFO full, draw_pixel and vga_ready in the same cycle -> head popped, new pixel accepted, count stays 4, overflow=0.
- Scan 60x14 block (dx 0..59, dy 0..13) at base (230,20) with vga_ready=1 -> 840 pixels, last at (289,33), pixel_count=840, clip_count=0.
- Queue 3 pixels, assert reset mid-drain -> vga_plot=0 and all outputs 0 immediately (async); after release no stale pixel appears.

Source files
------------

// File: rtl/draw_pixel_datapath.sv
// rtl/draw_pixel_datapath.sv - pixel position/colour latch, clip stage and output FIFO toward the VGA adapter
module draw_pixel_datapath #(
    parameter int         SCREEN_W    = 320,
    parameter int         SCREEN_H    = 240,
    parameter logic [8:0] TRANSPARENT = 9'h1FF,
    parameter int         DEPTH       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ld_xy,
    input  logic        ld_pos,
    input  logic        ld_colour,
    input  logic        draw_pixel,
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    input  logic [8:0]  dx,
    input  logic [8:0]  dy,
    input  logic [8:0]  colour,
    input  logic        clear_status,
    input  logic        vga_ready,
    output logic        vga_plot,
    output logic [8:0]  vga_x,
    output logic [8:0]  vga_y,
    output logic [8:0]  vga_colour,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] pixel_count,
    output logic [7:0]  clip_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [8:0]  base_x, base_y, col_reg;
    logic [9:0]  pos_x, pos_y;
    logic [26:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [8:0]  hold_x, hold_y, hold_colour;
    logic [26:0] head;
    logic        full, clipped, pop, push;

    assign head    = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign clipped = (pos_x >= 10'(SCREEN_W)) || (pos_y >= 10'(SCREEN_H)) ||
                     (col_reg == TRANSPARENT);
    assign pop     = (count != '0) && vga_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = draw_pixel && !clipped && (!full || pop);

    assign vga_plot   = (count != '0);
    assign busy       = vga_plot;
    assign vga_x      = vga_plot ? head[26:18] : hold_x;
    assign vga_y      = vga_plot ? head[17:9]  : hold_y;
    assign vga_colour = vga_plot ? head[8:0]   : hold_colour;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_x <= '0;
            base_y <= '0;
            pos_x  <= '0;
            pos_y  <= '0;
            col_reg <= '0;
        end else begin
            if (ld_xy) begin
                base_x <= x;
                base_y <= y;
            end
            if (ld_pos) begin
                pos_x <= {1'b0, base_x} + {1'b0, dx};
                pos_y <= {1'b0, base_y} + {1'b0, dy};
            end
            if (ld_colour) begin
                col_reg <= colour;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            hold_x      <= '0;
            hold_y      <= '0;
            hold_colour <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {pos_x[8:0], pos_y[8:0], col_reg};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + AW'(1);
                hold_x      <= head[26:18];
                hold_y      <= head[17:9];
                hold_colour <= head[8:0];
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            pixel_count <= '0;
            clip_count  <= '0;
        end else if (clear_status) begin
            overflow    <= 1'b0;
            pixel_count <= '0;
            clip_count  <= '0;
        end else begin
            if (draw_pixel && !clipped && full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop && (pixel_count != 16'hFFFF)) begin
                pixel_count <= pixel_count + 16'd1;
            end
            if (draw_pixel && clipped && (clip_count != 8'hFF)) begin
                clip_count <= clip_count + 8'd1;
            end
        end
    end
endmodule
